cpu_bus_arbiter: RTL and testbench
==================================

# cpu_bus_arbiter

Shares the single SRAM-like bus master port between instruction fetch and memory access stage of the five-stage MIPS pipeline. Runs one outstanding transaction at a time, data side has priority, and it produces the `stallreq_from_if` / `stallreq_from_mem` requests that the hazard unit consumes. Returned read data is held stable until the pipeline advances. Pending instruction fetches are discarded on exception flush.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  clock, rising edge
- `resetn`  in  1  reset, synchronous, active-low
- `inst_req`  in  1  IF requests fetch; held until served
- `inst_addr`  in  ADDR_W  fetch address
- `inst_rdata`  out  DATA_W  fetched word, held until pipeline advances
- `data_req`  in  1  MEM requests access; held until served
- `data_wr`  in  1  1 = store
- `data_size`  in  2  0 = byte, 1 = half, 2 = word
- `data_addr`  in  ADDR_W  access address
- `data_wdata`  in  DATA_W  store data
- `data_rdata`  out  DATA_W  load word, held until pipeline advances
- `pipe_stall`  in  1  pipeline not advancing this cycle
- `flush_except`  in  1  exception flush from hazard unit
- `stallreq_from_if`  out  1  `inst_req & ~inst_done`
- `stallreq_from_mem`  out  1  `data_req & ~data_done`
- `bus_req`, `bus_wr`  out  1  bus request and write flag
- `bus_size`  out  2  bus access size
- `bus_addr`  out  ADDR_W  bus address
- `bus_wdata`  out  DATA_W  bus write data
- `bus_addr_ok`  in  1  address accepted
- `bus_data_ok`  in  1  data returned or write done
- `bus_rdata`  in  DATA_W  bus read data

## Operation
- FSM has three states:
  - IDLE: arbitrates.
  - ADDR: `bus_req`=1 until `bus_addr_ok`.
  - WAIT: waits for `bus_data_ok`.
- Owner register is INST or DATA. It is latched together with the request fields when leaving IDLE.
- Arbitration in IDLE:
  - `data_req & ~data_done` wins.
  - Otherwise `inst_req & ~inst_done & ~flush_except` is served.
  - Otherwise the FSM stays in IDLE.
- Bus outputs are driven only from latched registers and are stable throughout ADDR.
- Completion:
  - On `bus_data_ok`, the owner's done flag is set.
  - For reads, `bus_rdata` is captured into the owner's rdata register.
  - A write leaves `data_rdata` unchanged.
- Done flags clear in any cycle with `~pipe_stall`. Clearing takes priority over a same-cycle completion only for the flag already set, never for the one being set.
- Flush behaviour:
  - `flush_except` clears `inst_done` and `data_done`.
  - If an INST transaction is in ADDR or WAIT, the `discard` flag is set. The bus transaction still completes, but it sets no done flag and writes no rdata.
  - A DATA transaction is never discarded.
- In ADDR, `bus_addr_ok` together with `bus_data_ok` in the same cycle completes the transaction and returns to IDLE.

## Timing
- All outputs reset to 0, FSM to IDLE, done and discard flags to 0.
- A reset in the middle of a transaction abandons it. The bus slave is required to be reset together with the arbiter.
- Minimum read latency:
  - Request seen in IDLE at cycle N.
  - `bus_req` is high at N+1.
  - `addr_ok` arrives at N+1, `data_ok` at N+2.
  - Done flag is set and stall drops at N+3, with rdata valid at N+3.
- Back-to-back transactions: IDLE always lasts at least one cycle between transactions.
- When both sides request at the same time, the data transaction runs first and `stallreq_from_if` stays high throughout.
- The stall outputs are combinational from the request inputs and the registered done flags.

## Configuration
- `CPU_BUS_ARB_PERF_CNT_EN` defined:
  - Adds outputs `perf_if_stall_cnt` and `perf_mem_stall_cnt`, each 32 bits, wrapping.
  - Each counter increments in every cycle its stall output is high and clears on reset.
- Undefined: these ports and the counters are absent. Behaviour is otherwise identical.

## Structure
- Package `cpu_bus_pkg` holds:
  - FSM state enum (IDLE/ADDR/WAIT).
  - Owner enum (INST/DATA).
  - Size constants (SIZE_B/H/W).
  - Width localparams.
- One sub-module, `cpu_bus_perf_cnt`, holding the two counters. It is instantiated only under the macro.

## Test plan
- Single fetch at 0xBFC00000, slave `addr_ok` at N+1 and `data_ok` at N+2 with 0x24080001 -> `inst_rdata`=0x24080001 at N+3, `stallreq_from_if` high for N..N+2.
- `inst_req` and `data_req` (load 0x80000010 -> 0xDEADBEEF) asserted in the same cycle -> bus sees the data address first and `data_rdata`=0xDEADBEEF. The inst transaction starts the cycle after data completes.
- Fetch complete with `pipe_stall`=1 for 4 cycles -> `inst_rdata` held, `stallreq_from_if`=0. After `pipe_stall` falls, done clears the next cycle.
- `flush_except` pulse while an INST transaction is in WAIT -> `data_ok` with 0x11111111 is ignored and `inst_rdata` keeps its old value. The new fetch is re-issued.
- Store word 0x12345678 to 0x80000020, `addr_ok` and `data_ok` in the same cycle -> `bus_wr`=1, `bus_size`=2, return to IDLE next cycle, `data_rdata` unchanged.
- With the macro defined: 10 cycles with `stallreq_from_mem` high -> `perf_mem_stall_cnt`=10.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared types, widths and access-size codes for the CPU bus arbiter.
package cpu_bus_pkg;

    localparam int CPU_ADDR_W = 32;
    localparam int CPU_DATA_W = 32;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef enum logic {
        INST = 1'b0,
        DATA = 1'b1
    } owner_e;

endpackage

// File: rtl/cpu_bus_arbiter_if.sv
// SRAM-like bus between the arbiter (master) and the memory slave.
interface cpu_bus_arbiter_if
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) ();

    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [ADDR_W-1:0] bus_addr;
    logic [DATA_W-1:0] bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [DATA_W-1:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_wr,
        output bus_size,
        output bus_addr,
        output bus_wdata,
        input  bus_addr_ok,
        input  bus_data_ok,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_wr,
        input  bus_size,
        input  bus_addr,
        input  bus_wdata,
        output bus_addr_ok,
        output bus_data_ok,
        output bus_rdata
    );

endinterface

// File: rtl/cpu_bus_perf_cnt.sv
// Free-running wrap-around counters of cycles spent stalled on fetch and on memory access.
module cpu_bus_perf_cnt (
    input  logic        clk,
    input  logic        resetn,
    input  logic        if_stall,
    input  logic        mem_stall,
    output logic [31:0] if_stall_cnt,
    output logic [31:0] mem_stall_cnt
);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            if_stall_cnt  <= 32'd0;
            mem_stall_cnt <= 32'd0;
        end else begin
            if (if_stall) begin
                if_stall_cnt <= if_stall_cnt + 32'd1;
            end
            if (mem_stall) begin
                mem_stall_cnt <= mem_stall_cnt + 32'd1;
            end
        end
    end

endmodule

// File: rtl/cpu_bus_arbiter.sv
// Shares one SRAM-like bus between instruction fetch and the memory stage, data side first.
// Define CPU_BUS_ARB_PERF_CNT_EN to add the stall performance counters.
module cpu_bus_arbiter
    import cpu_bus_pkg::*;
#(
    parameter int ADDR_W = CPU_ADDR_W,
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic [DATA_W-1:0] data_rdata,

    input  logic              pipe_stall,
    input  logic              flush_except,
    output logic              stallreq_from_if,
    output logic              stallreq_from_mem,

    cpu_bus_arbiter_if.master bus
`ifdef CPU_BUS_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_if_stall_cnt,
    output logic [31:0]       perf_mem_stall_cnt
`endif
);

    state_e state;
    owner_e owner;
    logic   discard;
    logic   inst_done;
    logic   data_done;

    logic   data_pend;
    logic   inst_pend;
    logic   bus_done;
    logic   inst_fin;
    logic   data_fin;
    logic   done_clr;

    assign data_pend = data_req & ~data_done;
    assign inst_pend = inst_req & ~inst_done & ~flush_except;

    // A transaction ends on data_ok in WAIT, or on addr_ok+data_ok together in ADDR.
    assign bus_done = (((state == ADDR) && bus.bus_addr_ok) || (state == WAIT)) && bus.bus_data_ok;
    assign inst_fin = bus_done && (owner == INST) && !discard && !flush_except;
    assign data_fin = bus_done && (owner == DATA);
    assign done_clr = ~pipe_stall | flush_except;

    assign stallreq_from_if  = inst_req & ~inst_done;
    assign stallreq_from_mem = data_pend;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            owner         <= INST;
            discard       <= 1'b0;
            inst_done     <= 1'b0;
            data_done     <= 1'b0;
            inst_rdata    <= '0;
            data_rdata    <= '0;
            bus.bus_req   <= 1'b0;
            bus.bus_wr    <= 1'b0;
            bus.bus_size  <= 2'd0;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (data_pend) begin
                        owner         <= DATA;
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= data_wr;
                        bus.bus_size  <= data_size;
                        bus.bus_addr  <= data_addr;
                        bus.bus_wdata <= data_wdata;
                        state         <= ADDR;
                    end else if (inst_pend) begin
                        owner         <= INST;
                        bus.bus_req   <= 1'b1;
                        bus.bus_wr    <= 1'b0;
                        bus.bus_size  <= SIZE_W;
                        bus.bus_addr  <= inst_addr;
                        bus.bus_wdata <= '0;
                        state         <= ADDR;
                    end
                end
                ADDR: begin
                    if (bus.bus_addr_ok) begin
                        bus.bus_req <= 1'b0;
                        state       <= bus.bus_data_ok ? IDLE : WAIT;
                    end
                end
                WAIT: begin
                    if (bus.bus_data_ok) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state       <= IDLE;
                    bus.bus_req <= 1'b0;
                end
            endcase

            // A flushed fetch still has to drain on the bus; only its result is dropped.
            if (bus_done) begin
                discard <= 1'b0;
            end else if (flush_except && (state != IDLE) && (owner == INST)) begin
                discard <= 1'b1;
            end

            if (inst_fin) begin
                inst_done  <= 1'b1;
                inst_rdata <= bus.bus_rdata;
            end else if (done_clr) begin
                inst_done <= 1'b0;
            end

            if (data_fin) begin
                data_done <= 1'b1;
                if (!bus.bus_wr) begin
                    data_rdata <= bus.bus_rdata;
                end
            end else if (done_clr) begin
                data_done <= 1'b0;
            end
        end
    end

`ifdef CPU_BUS_ARB_PERF_CNT_EN
    cpu_bus_perf_cnt u_perf_cnt (
        .clk           (clk),
        .resetn        (resetn),
        .if_stall      (stallreq_from_if),
        .mem_stall     (stallreq_from_mem),
        .if_stall_cnt  (perf_if_stall_cnt),
        .mem_stall_cnt (perf_mem_stall_cnt)
    );
`endif

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Bench for cpu_bus_arbiter: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a transaction-level model of the arbitration rules.
module tb_cpu_bus_arbiter;
    import cpu_bus_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        pipe_stall;
    logic        flush_except;
    logic        stallreq_from_if;
    logic        stallreq_from_mem;
`ifdef CPU_BUS_ARB_PERF_CNT_EN
    logic [31:0] perf_if_stall_cnt;
    logic [31:0] perf_mem_stall_cnt;
`endif

    cpu_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus_if ();

    cpu_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .inst_req          (inst_req),
        .inst_addr         (inst_addr),
        .inst_rdata        (inst_rdata),
        .data_req          (data_req),
        .data_wr           (data_wr),
        .data_size         (data_size),
        .data_addr         (data_addr),
        .data_wdata        (data_wdata),
        .data_rdata        (data_rdata),
        .pipe_stall        (pipe_stall),
        .flush_except      (flush_except),
        .stallreq_from_if  (stallreq_from_if),
        .stallreq_from_mem (stallreq_from_mem),
        .bus               (bus_if)
`ifdef CPU_BUS_ARB_PERF_CNT_EN
        ,
        .perf_if_stall_cnt (perf_if_stall_cnt),
        .perf_mem_stall_cnt(perf_mem_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: at most one outstanding transaction, described by its request fields.
    typedef struct packed {
        logic        is_data;
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        accepted;
        logic        discard;
    } txn_t;

    bit          busy;
    txn_t        cur;
    bit          m_inst_done;
    bit          m_data_done;
    logic [31:0] m_inst_rdata;
    logic [31:0] m_data_rdata;
    logic [31:0] m_perf_if;
    logic [31:0] m_perf_mem;

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_step();
        bit st_if;
        bit st_mem;
        bit done_now;
        bit clr;
        if (!resetn) begin
            busy         = 1'b0;
            cur          = '0;
            m_inst_done  = 1'b0;
            m_data_done  = 1'b0;
            m_inst_rdata = 32'd0;
            m_data_rdata = 32'd0;
            m_perf_if    = 32'd0;
            m_perf_mem   = 32'd0;
            return;
        end
        st_if      = inst_req && !m_inst_done;
        st_mem     = data_req && !m_data_done;
        m_perf_if  = m_perf_if + 32'(st_if);
        m_perf_mem = m_perf_mem + 32'(st_mem);
        done_now   = busy && bus_if.bus_data_ok && (cur.accepted || bus_if.bus_addr_ok);
        clr        = !pipe_stall || flush_except;

        if (done_now && !cur.is_data && !cur.discard && !flush_except) begin
            m_inst_done  = 1'b1;
            m_inst_rdata = bus_if.bus_rdata;
        end else if (clr) begin
            m_inst_done = 1'b0;
        end
        if (done_now && cur.is_data) begin
            m_data_done = 1'b1;
            if (!cur.wr) m_data_rdata = bus_if.bus_rdata;
        end else if (clr) begin
            m_data_done = 1'b0;
        end

        if (busy) begin
            if (done_now) begin
                busy = 1'b0;
            end else begin
                if (bus_if.bus_addr_ok) cur.accepted = 1'b1;
                if (flush_except && !cur.is_data) cur.discard = 1'b1;
            end
        end else if (st_mem) begin
            busy         = 1'b1;
            cur.is_data  = 1'b1;
            cur.wr       = data_wr;
            cur.size     = data_size;
            cur.addr     = data_addr;
            cur.wdata    = data_wdata;
            cur.accepted = 1'b0;
            cur.discard  = 1'b0;
        end else if (st_if && !flush_except) begin
            busy         = 1'b1;
            cur.is_data  = 1'b0;
            cur.wr       = 1'b0;
            cur.size     = SIZE_W;
            cur.addr     = inst_addr;
            cur.wdata    = 32'd0;
            cur.accepted = 1'b0;
            cur.discard  = 1'b0;
        end
    endtask

    task automatic checkOutput();
        bit exp_req;
        exp_req = busy && !cur.accepted;
        check_value("stallreq_from_if", 32'(stallreq_from_if), 32'(inst_req && !m_inst_done));
        check_value("stallreq_from_mem", 32'(stallreq_from_mem), 32'(data_req && !m_data_done));
        check_value("bus_req", 32'(bus_if.bus_req), 32'(exp_req));
        check_value("inst_rdata", inst_rdata, m_inst_rdata);
        check_value("data_rdata", data_rdata, m_data_rdata);
        if (exp_req) begin
            check_value("bus_wr", 32'(bus_if.bus_wr), 32'(cur.wr));
            check_value("bus_size", 32'(bus_if.bus_size), 32'(cur.size));
            check_value("bus_addr", bus_if.bus_addr, cur.addr);
            if (cur.wr) check_value("bus_wdata", bus_if.bus_wdata, cur.wdata);
        end
`ifdef CPU_BUS_ARB_PERF_CNT_EN
        check_value("perf_if_stall_cnt", perf_if_stall_cnt, m_perf_if);
        check_value("perf_mem_stall_cnt", perf_mem_stall_cnt, m_perf_mem);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic quiet_inputs();
        inst_req           = 1'b0;
        data_req           = 1'b0;
        data_wr            = 1'b0;
        pipe_stall         = 1'b0;
        flush_except       = 1'b0;
        bus_if.bus_addr_ok = 1'b0;
        bus_if.bus_data_ok = 1'b0;
    endtask

    task automatic applyStimulus();
        flush_except = ($urandom_range(0, 15) == 0);
        if (!(inst_req && !m_inst_done) || flush_except) begin
            inst_req  = ($urandom_range(0, 3) != 0);
            inst_addr = 32'hBFC0_0000 | ($urandom & 32'h0000_FFFC);
        end
        if (!(data_req && !m_data_done)) begin
            data_req   = ($urandom_range(0, 2) == 0);
            data_wr    = 1'($urandom_range(0, 1));
            data_size  = 2'($urandom_range(0, 2));
            data_addr  = 32'h8000_0000 | ($urandom & 32'h0000_FFFF);
            data_wdata = $urandom;
        end
        pipe_stall = (inst_req && !m_inst_done) || (data_req && !m_data_done) || ($urandom_range(0, 3) == 0);
        if (busy && !cur.accepted) begin
            bus_if.bus_addr_ok = 1'($urandom_range(0, 1));
            bus_if.bus_data_ok = bus_if.bus_addr_ok && ($urandom_range(0, 3) == 0);
        end else if (busy) begin
            bus_if.bus_addr_ok = 1'b0;
            bus_if.bus_data_ok = 1'($urandom_range(0, 1));
        end else begin
            bus_if.bus_addr_ok = 1'b0;
            bus_if.bus_data_ok = 1'b0;
        end
        bus_if.bus_rdata = $urandom;
    endtask

    initial begin
        resetn     = 1'b0;
        inst_addr  = 32'd0;
        data_size  = 2'd0;
        data_addr  = 32'd0;
        data_wdata = 32'd0;
        bus_if.bus_rdata = 32'd0;
        quiet_inputs();
        for (int i = 0; i < 3; i++) tick();
        check_value("rst_bus_req", 32'(bus_if.bus_req), 32'd0);
        check_value("rst_inst_rdata", inst_rdata, 32'd0);
        check_value("rst_data_rdata", data_rdata, 32'd0);
        check_value("rst_bus_addr", bus_if.bus_addr, 32'd0);
        resetn = 1'b1;
        tick();

`ifdef CPU_BUS_ARB_PERF_CNT_EN
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h8000_0000;
        pipe_stall = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_value("perf_mem_10", perf_mem_stall_cnt, 32'd10);
        check_value("perf_if_0", perf_if_stall_cnt, 32'd0);
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h0000_00AA;
        tick();
        quiet_inputs();
        tick();
`endif

        // Single fetch with minimum latency, then held result while the pipe is stalled.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0000; pipe_stall = 1'b1;
        #1 check_value("t1_stall_n", 32'(stallreq_from_if), 32'd1);
        tick();
        check_value("t1_bus_req", 32'(bus_if.bus_req), 32'd1);
        check_value("t1_bus_addr", bus_if.bus_addr, 32'hBFC0_0000);
        check_value("t1_stall_n1", 32'(stallreq_from_if), 32'd1);
        bus_if.bus_addr_ok = 1'b1;
        tick();
        check_value("t1_stall_n2", 32'(stallreq_from_if), 32'd1);
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h2408_0001;
        tick();
        check_value("t1_rdata_n3", inst_rdata, 32'h2408_0001);
        check_value("t1_stall_n3", 32'(stallreq_from_if), 32'd0);
        bus_if.bus_data_ok = 1'b0; bus_if.bus_rdata = 32'h5555_5555;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_value("t3_rdata_held", inst_rdata, 32'h2408_0001);
            check_value("t3_stall_low", 32'(stallreq_from_if), 32'd0);
        end
        pipe_stall = 1'b0;
        tick();
        check_value("t3_done_clear", 32'(stallreq_from_if), 32'd1);
        inst_req = 1'b0;
        tick();

        // Simultaneous fetch and load: data goes first.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b0; data_size = SIZE_W; data_addr = 32'h8000_0010;
        pipe_stall = 1'b1;
        tick();
        check_value("t2_first_addr", bus_if.bus_addr, 32'h8000_0010);
        check_value("t2_first_wr", 32'(bus_if.bus_wr), 32'd0);
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
        tick();
        check_value("t2_data_rdata", data_rdata, 32'hDEAD_BEEF);
        check_value("t2_stall_if", 32'(stallreq_from_if), 32'd1);
        check_value("t2_gap_idle", 32'(bus_if.bus_req), 32'd0);
        bus_if.bus_data_ok = 1'b0;
        tick();
        check_value("t2_inst_req", 32'(bus_if.bus_req), 32'd1);
        check_value("t2_inst_addr", bus_if.bus_addr, 32'hBFC0_0004);
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h8FA2_0000;
        tick();
        check_value("t2_inst_rdata", inst_rdata, 32'h8FA2_0000);
        quiet_inputs();
        tick();

        // Exception flush while a fetch waits for data.
        inst_req = 1'b1; inst_addr = 32'hBFC0_0008; pipe_stall = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b1;
        tick();
        bus_if.bus_addr_ok = 1'b0; flush_except = 1'b1; inst_addr = 32'hBFC0_0100;
        tick();
        flush_except = 1'b0; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h1111_1111;
        tick();
        check_value("t4_rdata_kept", inst_rdata, 32'h8FA2_0000);
        check_value("t4_stall_if", 32'(stallreq_from_if), 32'd1);
        bus_if.bus_data_ok = 1'b0;
        tick();
        check_value("t4_reissue_req", 32'(bus_if.bus_req), 32'd1);
        check_value("t4_reissue_addr", bus_if.bus_addr, 32'hBFC0_0100);
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'h3C1D_8000;
        tick();
        check_value("t4_new_rdata", inst_rdata, 32'h3C1D_8000);
        quiet_inputs();
        tick();

        // Store word with address and data acknowledged together.
        data_req = 1'b1; data_wr = 1'b1; data_size = SIZE_W;
        data_addr = 32'h8000_0020; data_wdata = 32'h1234_5678; pipe_stall = 1'b1;
        tick();
        check_value("t5_bus_wr", 32'(bus_if.bus_wr), 32'd1);
        check_value("t5_bus_size", 32'(bus_if.bus_size), 32'd2);
        check_value("t5_bus_wdata", bus_if.bus_wdata, 32'h1234_5678);
        bus_if.bus_addr_ok = 1'b1; bus_if.bus_data_ok = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
        tick();
        check_value("t5_idle", 32'(bus_if.bus_req), 32'd0);
        check_value("t5_stall_mem", 32'(stallreq_from_mem), 32'd0);
        check_value("t5_rdata_kept", data_rdata, 32'hDEAD_BEEF);
        quiet_inputs();
        tick();

        // Randomized traffic with a reset in the middle.
        for (int c = 0; c < 4000; c++) begin
            resetn = !(c == 2000 || c == 2001);
            applyStimulus();
            tick();
        end

        $display("[TB] random phase complete");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
